gr_bank_arbiter: RTL and testbench
==================================

Name: gr_bank_arbiter

Overview:
Arbitrates and sequences access to the shared bank of general registers between two requesters: requester 0 is the AMBA-side bus, requester 1 is the local core. It grants one requester at a time (round-robin) and drives the bank's broadcast read_flag, write_flag, address and write data for exactly one cycle per access. It captures read data and returns a one-cycle acknowledge, with an error flag for illegal accesses.

Parameters:
DATA_WIDTH, 8, width of address and data on all ports
NUM_REGS, 16, number of registers in the bank; legal addresses are 0..NUM_REGS-1

Ports:
SYS_CLK  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset; rst=0 resets
r0_req  input  1  requester 0 access request; held high until r0_ack
r0_write  input  1  1=write, 0=read; valid with r0_req
r0_addr  input  DATA_WIDTH  register address
r0_wdata  input  DATA_WIDTH  write data
r0_ack  output  1  one-cycle completion pulse
r0_err  output  1  valid with r0_ack; 1=access rejected
r0_rdata  output  DATA_WIDTH  read data; valid with r0_ack
r1_req, r1_write, r1_addr, r1_wdata, r1_ack, r1_err, r1_rdata: same as r0_*, for requester 1
wr_lock  input  1  1=writes from requester 1 rejected
busy  output  1  1 while FSM not IDLE
read_flag  output  1  bank read strobe
write_flag  output  1  bank write strobe
amba_addr  output  DATA_WIDTH  bank address broadcast
data_in  output  DATA_WIDTH  bank write data
data_out  input  DATA_WIDTH  bank read data; valid the cycle after read_flag

Behaviour:
- All outputs registered. Reset values: every ack/err/flag/busy = 0; amba_addr, data_in, r0_rdata, r1_rdata = 0; FSM = IDLE; last_grant = 1.
- FSM states are IDLE, ISSUE, WAIT_RD and RESP.
- IDLE: if no req, stay. Grant rules:
  - Only one req high: grant it.
  - Both high: grant the requester opposite last_grant, so requester 0 wins the first tie after reset.
  - On grant, latch id, write, addr and wdata, and set last_grant = id.
- Error check at grant. The access is illegal if addr >= NUM_REGS, or if id=1, write=1 and wr_lock=1 (wr_lock sampled at grant only).
  - Illegal: go to RESP with err=1. The bank is not touched.
  - Legal: go to ISSUE.
- ISSUE (exactly 1 cycle): amba_addr = latched addr.
  - Write: write_flag=1, data_in = latched wdata, then go to RESP.
  - Read: read_flag=1, then go to WAIT_RD.
  - The two flags are never high together. Both are 0 in every other state.
- amba_addr and data_in hold their last values outside ISSUE.
- WAIT_RD (1 cycle): sample data_out into the granted requester's rdata register; go to RESP.
- RESP (1 cycle): rN_ack=1 for the granted id only; rN_err per the error check; go to IDLE.
  - Write or error: rN_rdata = 0.
  - Read: rN_rdata holds the captured value until that requester's next ack.
- Latency, counted with req sampled in IDLE at cycle 0:
  - ack at cycle 2 for a write.
  - ack at cycle 3 for a read.
  - ack at cycle 1 for an error.
- Requester protocol:
  - A requester drops req on the edge where it sees ack.
  - A req still high in the IDLE cycle after RESP is a new transaction (back-to-back).
  - Request fields must be stable while req=1 and before ack.
- A requester that is not granted keeps req high and waits; it is served at the next IDLE (fairness: at most one foreign transaction in between).
- busy=1 in ISSUE, WAIT_RD and RESP.
- Asynchronous reset mid-operation:
  - All state returns to reset values immediately and any in-flight access is dropped (no ack).
  - A write already strobed in ISSUE may have landed in the bank.
  - Requesters must reissue.
- Addresses are unsigned and compared at full DATA_WIDTH; there is no wrap-around.

Test Plan:
- Reset, then r0 writes addr 3 = 0xA5 -> write_flag=1, amba_addr=3, data_in=0xA5 in cycle 1; r0_ack=1, r0_err=0 in cycle 2. A following r0 read of addr 3 -> read_flag in cycle 1; r0_ack in cycle 3 with r0_rdata=0xA5.
- r0 and r1 both request reads in the same cycle right after reset -> r0 is granted first, r1 is acked 4 cycles after r0's ack. A repeated tie -> r1 is granted first.
- r1 writes addr 2 = 0x3C with wr_lock=1 -> r1_ack and r1_err=1 at cycle 1, write_flag never high. With wr_lock=0 -> normal write.
- r0 reads addr 16 (NUM_REGS=16) -> r0_err=1, r0_rdata=0 at cycle 1, read_flag never high. Addr 15 -> normal access.
- r0 holds req across back-to-back writes to addrs 0..3 -> four acks at 3-cycle spacing, and read_flag/write_flag are never high together.
- Assert rst=0 during WAIT_RD of an r1 read -> busy, flags, acks and rdata are 0 immediately. After release, with no req, the block idles; a reissued read completes with correct data.

Source files
------------

// File: rtl/gr_bank_arbiter_if.sv
// Requester-side access channel of the general-register bank arbiter.
// The requester drives request and access fields; the arbiter returns ack, err and read data.
interface gr_bank_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req;
  logic                  write;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic                  err;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, write, addr, wdata,
    input  ack, err, rdata
  );

  modport slave (
    input  req, write, addr, wdata,
    output ack, err, rdata
  );
endinterface

// File: rtl/gr_bank_arbiter.sv
// Round-robin arbiter and sequencer for the shared general-register bank,
// serving the AMBA-side requester (r0) and the local core (r1) one access at a time.
module gr_bank_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                  SYS_CLK,
  input  logic                  rst,
  gr_bank_arbiter_if.slave      r0,
  gr_bank_arbiter_if.slave      r1,
  input  logic                  wr_lock,
  output logic                  busy,
  output logic                  read_flag,
  output logic                  write_flag,
  output logic [DATA_WIDTH-1:0] amba_addr,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_out
);

  // One extra bit so the bound compares correctly even when NUM_REGS == 2**DATA_WIDTH.
  localparam logic [DATA_WIDTH:0] NUM_REGS_C = (DATA_WIDTH + 1)'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_e;

  state_e                state_r;
  logic                  last_grant_r;
  logic                  id_r;
  logic                  write_r;
  logic                  r0_ack_r;
  logic                  r0_err_r;
  logic [DATA_WIDTH-1:0] r0_rdata_r;
  logic                  r1_ack_r;
  logic                  r1_err_r;
  logic [DATA_WIDTH-1:0] r1_rdata_r;

  logic                  grant_valid_s;
  logic                  grant_id_s;
  logic                  sel_write_s;
  logic [DATA_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic                  illegal_s;

  assign r0.ack   = r0_ack_r;
  assign r0.err   = r0_err_r;
  assign r0.rdata = r0_rdata_r;
  assign r1.ack   = r1_ack_r;
  assign r1.err   = r1_err_r;
  assign r1.rdata = r1_rdata_r;

  // Grant selection and legality check for the request seen in IDLE.
  always_comb begin
    grant_valid_s = r0.req | r1.req;
    if (r0.req && r1.req) begin
      grant_id_s = ~last_grant_r;
    end else if (r1.req) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
    if (grant_id_s) begin
      sel_write_s = r1.write;
      sel_addr_s  = r1.addr;
      sel_wdata_s = r1.wdata;
    end else begin
      sel_write_s = r0.write;
      sel_addr_s  = r0.addr;
      sel_wdata_s = r0.wdata;
    end
    illegal_s = ({1'b0, sel_addr_s} >= NUM_REGS_C) ||
                (grant_id_s && sel_write_s && wr_lock);
  end

  // Access sequencer: every output is a register loaded on entry to the state it belongs to.
  always_ff @(posedge SYS_CLK or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      id_r         <= 1'b0;
      write_r      <= 1'b0;
      busy         <= 1'b0;
      read_flag    <= 1'b0;
      write_flag   <= 1'b0;
      amba_addr    <= {DATA_WIDTH{1'b0}};
      data_in      <= {DATA_WIDTH{1'b0}};
      r0_ack_r     <= 1'b0;
      r0_err_r     <= 1'b0;
      r0_rdata_r   <= {DATA_WIDTH{1'b0}};
      r1_ack_r     <= 1'b0;
      r1_err_r     <= 1'b0;
      r1_rdata_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      r0_ack_r   <= 1'b0;
      r0_err_r   <= 1'b0;
      r1_ack_r   <= 1'b0;
      r1_err_r   <= 1'b0;
      read_flag  <= 1'b0;
      write_flag <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            id_r         <= grant_id_s;
            write_r      <= sel_write_s;
            last_grant_r <= grant_id_s;
            busy         <= 1'b1;
            if (illegal_s) begin
              // Rejected accesses skip the bank entirely and answer next cycle.
              state_r <= RESP;
              if (grant_id_s) begin
                r1_ack_r   <= 1'b1;
                r1_err_r   <= 1'b1;
                r1_rdata_r <= {DATA_WIDTH{1'b0}};
              end else begin
                r0_ack_r   <= 1'b1;
                r0_err_r   <= 1'b1;
                r0_rdata_r <= {DATA_WIDTH{1'b0}};
              end
            end else begin
              state_r   <= ISSUE;
              amba_addr <= sel_addr_s;
              if (sel_write_s) begin
                write_flag <= 1'b1;
                data_in    <= sel_wdata_s;
              end else begin
                read_flag <= 1'b1;
              end
            end
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        ISSUE: begin
          if (write_r) begin
            state_r <= RESP;
            if (id_r) begin
              r1_ack_r   <= 1'b1;
              r1_rdata_r <= {DATA_WIDTH{1'b0}};
            end else begin
              r0_ack_r   <= 1'b1;
              r0_rdata_r <= {DATA_WIDTH{1'b0}};
            end
          end else begin
            state_r <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // Bank data is valid the cycle after read_flag.
          state_r <= RESP;
          if (id_r) begin
            r1_ack_r   <= 1'b1;
            r1_rdata_r <= data_out;
          end else begin
            r0_ack_r   <= 1'b1;
            r0_rdata_r <= data_out;
          end
        end
        RESP: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gr_bank_arbiter.sv
// Self-checking bench for gr_bank_arbiter: latency-table transaction model plus directed scenarios.
module tb_gr_bank_arbiter;
  localparam int DW = 8;
  localparam int NR = 16;

  logic          SYS_CLK = 1'b0;
  logic          rst = 1'b0;
  logic          wr_lock = 1'b0;
  logic          busy, read_flag, write_flag;
  logic [DW-1:0] amba_addr, data_in;
  logic [DW-1:0] data_out = 8'h00;
  logic [DW-1:0] bank_mem [NR] = '{default: 8'h00};

  gr_bank_arbiter_if #(.DATA_WIDTH(DW)) r0_if ();
  gr_bank_arbiter_if #(.DATA_WIDTH(DW)) r1_if ();

  gr_bank_arbiter #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .SYS_CLK(SYS_CLK), .rst(rst), .r0(r0_if), .r1(r1_if), .wr_lock(wr_lock),
    .busy(busy), .read_flag(read_flag), .write_flag(write_flag),
    .amba_addr(amba_addr), .data_in(data_in), .data_out(data_out)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // Register bank behind the arbiter; read data appears the cycle after read_flag.
  always @(posedge SYS_CLK) begin
    if (write_flag) bank_mem[amba_addr[3:0]] <= data_in;
    if (read_flag) data_out <= bank_mem[amba_addr[3:0]];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Expected outputs per cycle, filled from the latency table at grant time.
  typedef struct packed {
    logic busy, rf, wf, ack0, ack1, err0, err1, set_addr, set_din, set_rd0, set_rd1;
    logic [7:0] addr, din, rd0, rd1;
  } exp_t;

  exp_t       ring [8];
  int         m_free = 0;
  logic       m_last = 1'b1;
  logic [7:0] m_mem [NR] = '{default: 8'h00};
  logic [7:0] m_addr_o = 8'h00, m_din_o = 8'h00, m_rd0 = 8'h00, m_rd1 = 8'h00;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ring[i] = '0;
    m_free = 0;
    m_last = 1'b1;
    m_addr_o = 8'h00;
    m_din_o = 8'h00;
    m_rd0 = 8'h00;
    m_rd1 = 8'h00;
  endtask

  task automatic set_ack(input int i, input logic id, input logic e, input logic [7:0] v);
    if (id) begin
      ring[i].ack1 = 1'b1; ring[i].err1 = e; ring[i].set_rd1 = 1'b1; ring[i].rd1 = v;
    end else begin
      ring[i].ack0 = 1'b1; ring[i].err0 = e; ring[i].set_rd0 = 1'b1; ring[i].rd0 = v;
    end
  endtask

  // Grant the request sampled in the idle cycle that just ended; cyc is the first cycle after it.
  task automatic schedule();
    logic id, w, bad;
    logic [7:0] a, d;
    int i1, i2, i3;
    if (r0_if.req && r1_if.req) id = ~m_last;
    else id = r1_if.req;
    w = id ? r1_if.write : r0_if.write;
    a = id ? r1_if.addr : r0_if.addr;
    d = id ? r1_if.wdata : r0_if.wdata;
    m_last = id;
    bad = (int'(a) >= NR) || (id && w && wr_lock);
    i1 = cyc % 8; i2 = (cyc + 1) % 8; i3 = (cyc + 2) % 8;
    if (bad) begin
      ring[i1].busy = 1'b1;
      set_ack(i1, id, 1'b1, 8'h00);
      m_free = cyc + 1;
    end else if (w) begin
      ring[i1].busy = 1'b1; ring[i1].wf = 1'b1;
      ring[i1].set_addr = 1'b1; ring[i1].addr = a;
      ring[i1].set_din = 1'b1; ring[i1].din = d;
      ring[i2].busy = 1'b1;
      set_ack(i2, id, 1'b0, 8'h00);
      m_mem[a[3:0]] = d;
      m_free = cyc + 2;
    end else begin
      ring[i1].busy = 1'b1; ring[i1].rf = 1'b1;
      ring[i1].set_addr = 1'b1; ring[i1].addr = a;
      ring[i2].busy = 1'b1;
      ring[i3].busy = 1'b1;
      set_ack(i3, id, 1'b0, m_mem[a[3:0]]);
      m_free = cyc + 3;
    end
  endtask

  always @(posedge SYS_CLK) begin
    cyc = cyc + 1;
    if (!rst) model_reset();
    else if ((r0_if.req || r1_if.req) && (cyc - 1 >= m_free)) schedule();
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge SYS_CLK) begin
    exp_t e;
    int idx;
    if (!rst) begin
      check("reset_outputs", {busy, read_flag, write_flag, r0_if.ack, r1_if.ack,
             r0_if.err, r1_if.err, r0_if.rdata, r1_if.rdata, amba_addr, data_in}, 32'h0);
    end else begin
      idx = cyc % 8;
      e = ring[idx];
      if (e.set_addr) m_addr_o = e.addr;
      if (e.set_din) m_din_o = e.din;
      if (e.set_rd0) m_rd0 = e.rd0;
      if (e.set_rd1) m_rd1 = e.rd1;
      check("busy", busy, e.busy);
      check("read_flag", read_flag, e.rf);
      check("write_flag", write_flag, e.wf);
      check("flag_exclusive", read_flag & write_flag, 1'b0);
      check("r0_ack", r0_if.ack, e.ack0);
      check("r1_ack", r1_if.ack, e.ack1);
      if (e.ack0) check("r0_err", r0_if.err, e.err0);
      if (e.ack1) check("r1_err", r1_if.err, e.err1);
      check("amba_addr", amba_addr, m_addr_o);
      check("data_in", data_in, m_din_o);
      check("r0_rdata", r0_if.rdata, m_rd0);
      check("r1_rdata", r1_if.rdata, m_rd1);
      ring[idx] = '0;
    end
  end

  // One requester transaction, started just after a negedge in an idle cycle.
  task automatic do_req(input logic id, input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int exp_lat, input logic exp_err, input logic [7:0] exp_rd,
                        input string name);
    int n = 0;
    logic got = 1'b0;
    if (id) begin
      r1_if.req = 1'b1; r1_if.write = w; r1_if.addr = a; r1_if.wdata = d;
    end else begin
      r0_if.req = 1'b1; r0_if.write = w; r0_if.addr = a; r0_if.wdata = d;
    end
    while (n < 30 && !got) begin
      @(negedge SYS_CLK);
      n++;
      got = id ? r1_if.ack : r0_if.ack;
    end
    if (id) r1_if.req = 1'b0;
    else r0_if.req = 1'b0;
    check({name, "_acked"}, got, 1'b1);
    check({name, "_latency"}, n, exp_lat);
    if (got) begin
      check({name, "_err"}, id ? r1_if.err : r0_if.err, exp_err);
      check({name, "_rdata"}, id ? r1_if.rdata : r0_if.rdata, exp_rd);
    end
  endtask

  task automatic do_reset();
    @(posedge SYS_CLK);
    #3 rst = 1'b0;
    repeat (2) @(posedge SYS_CLK);
    #3 rst = 1'b1;
    @(negedge SYS_CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic got;
    r0_if.req = 1'b0; r0_if.write = 1'b0; r0_if.addr = 8'h00; r0_if.wdata = 8'h00;
    r1_if.req = 1'b0; r1_if.write = 1'b0; r1_if.addr = 8'h00; r1_if.wdata = 8'h00;
    repeat (3) @(posedge SYS_CLK);
    #1 check("init_busy", busy, 1'b0);
    check("init_acks", {r0_if.ack, r1_if.ack}, 2'b00);
    #2 rst = 1'b1;
    @(negedge SYS_CLK);

    // Write then read back through requester 0.
    do_req(1'b0, 1'b1, 8'd3, 8'hA5, 2, 1'b0, 8'h00, "r0_wr3");
    @(negedge SYS_CLK);
    do_req(1'b0, 1'b0, 8'd3, 8'h00, 3, 1'b0, 8'hA5, "r0_rd3");

    // First tie after reset goes to r0; r1 follows four cycles later.
    do_reset();
    fork
      do_req(1'b0, 1'b0, 8'd3, 8'h00, 3, 1'b0, 8'hA5, "tie1_r0");
      do_req(1'b1, 1'b0, 8'd3, 8'h00, 7, 1'b0, 8'hA5, "tie1_r1");
    join
    @(negedge SYS_CLK);

    // Top legal address, and a tie after r0 was granted last goes to r1.
    do_req(1'b0, 1'b1, 8'd15, 8'h5A, 2, 1'b0, 8'h00, "r0_wr15");
    @(negedge SYS_CLK);
    fork
      do_req(1'b0, 1'b0, 8'd15, 8'h00, 7, 1'b0, 8'h5A, "tie2_r0");
      do_req(1'b1, 1'b0, 8'd15, 8'h00, 3, 1'b0, 8'h5A, "tie2_r1");
    join
    @(negedge SYS_CLK);

    // Write lock rejects r1 writes without touching the bank.
    wr_lock = 1'b1;
    do_req(1'b1, 1'b1, 8'd2, 8'h3C, 1, 1'b1, 8'h00, "r1_locked_wr");
    @(negedge SYS_CLK);
    do_req(1'b1, 1'b0, 8'd2, 8'h00, 3, 1'b0, 8'h00, "r1_rd2_after_lock");
    wr_lock = 1'b0;
    @(negedge SYS_CLK);
    do_req(1'b1, 1'b1, 8'd2, 8'h3C, 2, 1'b0, 8'h00, "r1_unlocked_wr");
    @(negedge SYS_CLK);
    do_req(1'b1, 1'b0, 8'd2, 8'h00, 3, 1'b0, 8'h3C, "r1_rd2");
    @(negedge SYS_CLK);

    // Out-of-range address is rejected and clears r0_rdata (previously 0x5A).
    do_req(1'b0, 1'b0, 8'd16, 8'h00, 1, 1'b1, 8'h00, "r0_rd16");
    @(negedge SYS_CLK);
    do_req(1'b0, 1'b0, 8'd255, 8'h00, 1, 1'b1, 8'h00, "r0_rd255");
    @(negedge SYS_CLK);

    // Back-to-back writes with req held high: acks 3 cycles apart.
    r0_if.req = 1'b1; r0_if.write = 1'b1; r0_if.addr = 8'd0; r0_if.wdata = 8'h10;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      got = 1'b0;
      while (n < 30 && !got) begin
        @(negedge SYS_CLK);
        n++;
        got = r0_if.ack;
      end
      check("b2b_acked", got, 1'b1);
      check("b2b_spacing", n, (i == 0) ? 2 : 3);
      if (i < 3) begin
        r0_if.addr = 8'(i + 1);
        r0_if.wdata = 8'(8'h11 + i);
      end else begin
        r0_if.req = 1'b0;
      end
    end
    @(negedge SYS_CLK);
    do_req(1'b0, 1'b0, 8'd15, 8'h00, 3, 1'b0, 8'h5A, "r0_rd15");
    @(negedge SYS_CLK);

    // Reset during WAIT_RD of an r1 read drops the access.
    r1_if.req = 1'b1; r1_if.write = 1'b0; r1_if.addr = 8'd2;
    @(posedge SYS_CLK);
    @(posedge SYS_CLK);
    #1 check("pre_reset_busy", busy, 1'b1);
    check("pre_reset_r1_rdata", r1_if.rdata, 8'h3C);
    #2 rst = 1'b0;
    r1_if.req = 1'b0;
    #1 check("midrst_busy", busy, 1'b0);
    check("midrst_flags", {read_flag, write_flag}, 2'b00);
    check("midrst_acks", {r0_if.ack, r1_if.ack}, 2'b00);
    check("midrst_rdata", {r0_if.rdata, r1_if.rdata}, 16'h0000);
    repeat (3) @(posedge SYS_CLK);
    #3 rst = 1'b1;
    repeat (3) @(negedge SYS_CLK);
    check("idle_after_reset", busy, 1'b0);
    do_req(1'b1, 1'b0, 8'd2, 8'h00, 3, 1'b0, 8'h12, "r1_reissue_rd2");
    repeat (3) @(negedge SYS_CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
